// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding common to RX and TX, parity
// selector values and the default payload width.
package uart_pkg;
  localparam int DEF_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_t;

  // Parity bit for a frame given the XOR-reduction of its payload.
  function automatic logic par_bit(input logic data_xor, input logic typ);
    return (typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// Upstream-facing handshake and serial-side outputs of the UART transmitter.
interface uart_tx_if #(parameter int DATA_WIDTH = uart_pkg::DEF_DATA_WIDTH);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (output p_data, data_valid, par_en, par_typ, input tx_out, busy);
  modport slave  (input p_data, data_valid, par_en, par_typ, output tx_out, busy);
endinterface

// File: rtl/uart_tx_fsm.sv
// UART TX sequencing: state register, bit counter and busy flag. Exports the
// next state/bit index so the top can register tx_out in the same edge.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic          i_par_en,
  output logic          o_accept,
  output state_t        o_sel,
  output logic [CW-1:0] o_bit_idx,
  output logic          o_busy
);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  state_t        r_state, w_nxt_state;
  logic [CW-1:0] r_bit_cnt, w_nxt_cnt;
  logic          r_busy;
  logic          w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_bit_cnt <= w_nxt_cnt;
      r_busy    <= (w_nxt_state != S_IDLE);
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_bit_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_accept    = 1'b1;
          w_nxt_state = S_START;
          w_nxt_cnt   = '0;
        end
      end
      S_START:  w_nxt_state = S_DATA;
      S_DATA: begin
        if (r_bit_cnt == LAST) w_nxt_state = i_par_en ? S_PARITY : S_STOP;
        else                   w_nxt_cnt   = r_bit_cnt + 1'b1;
      end
      S_PARITY: w_nxt_state = S_STOP;
      S_STOP: begin
        // A request seen during the stop bit chains the next frame directly.
        if (i_valid) begin
          w_accept    = 1'b1;
          w_nxt_state = S_START;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  assign o_accept  = w_accept;
  assign o_sel     = w_nxt_state;
  assign o_bit_idx = w_nxt_cnt;
  assign o_busy    = r_busy;
endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: latches payload/config on acceptance and drives the
// registered serial line (start, LSB-first data, optional parity, stop).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic     clk,
  input logic     rst,
  uart_tx_if.slave bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_tx_out;
  logic                  w_accept;
  logic                  w_busy;
  state_t                w_sel;
  logic [CW-1:0]         w_bit_idx;
  logic                  w_tx_nxt;

  uart_tx_fsm #(.DATA_WIDTH(DATA_WIDTH), .CW(CW)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (bus.data_valid),
    .i_par_en  (r_par_en),
    .o_accept  (w_accept),
    .o_sel     (w_sel),
    .o_bit_idx (w_bit_idx),
    .o_busy    (w_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= PAR_EVEN;
    end else if (w_accept) begin
      r_data    <= bus.p_data;
      r_par_en  <= bus.par_en;
      r_par_typ <= bus.par_typ;
    end
  end

  // Mux keyed on the next state so the line bit lands with the state change;
  // on acceptance the start bit needs no payload, so the latch timing is safe.
  always_comb begin
    w_tx_nxt = 1'b1;
    unique case (w_sel)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = r_data[w_bit_idx];
      S_PARITY: w_tx_nxt = par_bit(^r_data, r_par_typ);
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_tx_out <= 1'b1;
    else     r_tx_out <= w_tx_nxt;
  end

  assign bus.tx_out = r_tx_out;
  assign bus.busy   = w_busy;
endmodule
